// File: rtl/axil_reg_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axil_pkg                                                         |
// | Brief    : Response codes, FSM state types and range-response helper.      |
// |            Optional macro AXIL_OOR_SLVERR_EN selects SLVERR for OOR access. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

`ifdef AXIL_OOR_SLVERR_EN
  localparam logic c_oor_slverr = 1'b1;
`else
  localparam logic c_oor_slverr = 1'b0;
`endif

  function automatic logic [1:0] range_resp(input logic oor);
    return (oor && c_oor_slverr) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_reg_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axil_reg_responder_if                                            |
// | Brief    : AXI4-Lite bus bundle with master and slave modports.             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface axil_reg_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface
`default_nettype wire

// File: rtl/axil_reg_responder_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axil_regfile                                                     |
// | Brief    : Word register file, byte-strobed write, registered bus read and  |
// |            combinational user read, asynchronous clear.                     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module axil_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic [IDX_W-1:0]      usr_idx,
  output logic [DATA_WIDTH-1:0] usr_rdata
);

  localparam logic [IDX_W:0] c_num_regs = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_bus_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) r_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Sampled on the same edge as a write, so a colliding read sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_rdata <= '0;
    end else if (rd_en) begin
      r_bus_rdata <= rd_clr ? '0 : r_mem[rd_idx];
    end
  end

  assign bus_rdata = r_bus_rdata;
  assign usr_rdata = ({1'b0, usr_idx} < c_num_regs) ? r_mem[usr_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/axil_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axil_reg_responder                                               |
// | Brief    : AXI4-Lite register responder with user read port and write pulse.|
// |            Macro AXIL_OOR_SLVERR_EN: out-of-range accesses answer SLVERR.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module axil_reg_responder
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axil_reg_responder_if.slave         s_axil,
  input  logic [$clog2(NUM_REGS)-1:0] usr_raddr,
  output logic [DATA_WIDTH-1:0]       usr_rdata,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_index
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int AIDX_W = ADDR_WIDTH - 2;
  localparam logic [AIDX_W:0] c_num_regs = (AIDX_W + 1)'(NUM_REGS);

  // ---------------- write channel ----------------
  wr_state_t             r_wstate, w_wstate_nxt;
  logic                  r_aw_done, r_w_done;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [1:0]            r_bresp;
  logic                  r_wr_pulse;
  logic [IDX_W-1:0]      r_wr_index;

  logic                  w_aw_hs, w_w_hs, w_commit, w_wr_oor;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic [AIDX_W-1:0]     w_widx;

  assign s_axil.awready = (r_wstate == W_IDLE) && !r_aw_done;
  assign s_axil.wready  = (r_wstate == W_IDLE) && !r_w_done;
  assign s_axil.bvalid  = (r_wstate == W_RESP);
  assign s_axil.bresp   = r_bresp;

  assign w_aw_hs = s_axil.awvalid && s_axil.awready;
  assign w_w_hs  = s_axil.wvalid && s_axil.wready;

  // Whichever half arrives second is used straight off the bus.
  assign w_waddr  = r_aw_done ? r_awaddr : s_axil.awaddr;
  assign w_wdata  = r_w_done ? r_wdata : s_axil.wdata;
  assign w_wstrb  = r_w_done ? r_wstrb : s_axil.wstrb;
  assign w_widx   = w_waddr[ADDR_WIDTH-1:2];
  assign w_wr_oor = ({1'b0, w_widx} >= c_num_regs);
  assign w_commit = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axil.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= AXIL_RESP_OKAY;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_wr_pulse <= w_commit && !w_wr_oor;
      if (w_commit) begin
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_bresp    <= range_resp(w_wr_oor);
        r_wr_index <= w_widx[IDX_W-1:0];
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
          r_awaddr  <= s_axil.awaddr;
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
          r_wdata  <= s_axil.wdata;
          r_wstrb  <= s_axil.wstrb;
        end
      end
    end
  end

  assign wr_pulse = r_wr_pulse;
  assign wr_index = r_wr_index;

  // ---------------- read channel ----------------
  rd_state_t         r_rstate, w_rstate_nxt;
  logic [1:0]        r_rresp;
  logic              w_ar_hs, w_rd_oor;
  logic [AIDX_W-1:0] w_ridx;

  assign s_axil.arready = (r_rstate == R_IDLE);
  assign s_axil.rvalid  = (r_rstate == R_RESP);
  assign s_axil.rresp   = r_rresp;

  assign w_ar_hs  = s_axil.arvalid && s_axil.arready;
  assign w_ridx   = s_axil.araddr[ADDR_WIDTH-1:2];
  assign w_rd_oor = ({1'b0, w_ridx} >= c_num_regs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (s_axil.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rresp <= AXIL_RESP_OKAY;
    else if (w_ar_hs) r_rresp <= range_resp(w_rd_oor);
  end

  axil_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_commit && !w_wr_oor),
    .wr_idx    (w_widx[IDX_W-1:0]),
    .wr_data   (w_wdata),
    .wr_strb   (w_wstrb),
    .rd_en     (w_ar_hs),
    .rd_clr    (w_rd_oor),
    .rd_idx    (w_ridx[IDX_W-1:0]),
    .bus_rdata (s_axil.rdata),
    .usr_idx   (usr_raddr),
    .usr_rdata (usr_rdata)
  );

  // Byte-lane address bits carry no meaning for word registers.
  logic w_unused;
  assign w_unused = &{1'b0, w_waddr[1:0], s_axil.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axil_reg_responder                                            |
// | Brief    : Scoreboard bench for axil_reg_responder (honours               |
// |            AXIL_OOR_SLVERR_EN).                                             |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axil_reg_responder;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

`ifdef AXIL_OOR_SLVERR_EN
  localparam logic [1:0] c_oor_resp = 2'b10;
`else
  localparam logic [1:0] c_oor_resp = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  usr_raddr;
  logic [31:0] usr_rdata;
  logic        wr_pulse;
  logic [3:0]  wr_index;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [16];
  logic [1:0]  exp_b  [$];
  logic [3:0]  exp_wi [$];
  rexp_t       exp_r  [$];

  axil_reg_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .STRB_WIDTH(4)) s_axil ();

  axil_reg_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .STRB_WIDTH (4),
    .NUM_REGS   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axil    (s_axil),
    .usr_raddr (usr_raddr),
    .usr_rdata (usr_rdata),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: pops expectations as the DUT produces results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_axil.bvalid && s_axil.bready) begin
        if (exp_b.size() == 0) check_eq("b_unexpected", 1, 0);
        else check_eq("bresp", {30'd0, s_axil.bresp}, {30'd0, exp_b.pop_front()});
      end
      if (wr_pulse) begin
        if (exp_wi.size() == 0) check_eq("wr_pulse_unexpected", 1, 0);
        else check_eq("wr_index", {28'd0, wr_index}, {28'd0, exp_wi.pop_front()});
      end
      if (s_axil.rvalid && s_axil.rready) begin
        if (exp_r.size() == 0) check_eq("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = exp_r.pop_front();
          check_eq("rdata", s_axil.rdata, e.data);
          check_eq("rresp", {30'd0, s_axil.rresp}, {30'd0, e.resp});
        end
      end
    end
  end

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx;
    idx = int'(addr[7:2]);
    if (idx < 16) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_wi.push_back(idx[3:0]);
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(c_oor_resp);
    end
  endfunction

  function automatic rexp_t model_read(input logic [7:0] addr);
    rexp_t e;
    int idx;
    idx = int'(addr[7:2]);
    if (idx < 16) begin e.data = model[idx]; e.resp = 2'b00; end
    else          begin e.data = 32'd0;      e.resp = c_oor_resp; end
    return e;
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_lead);
    bit aw_sent, w_sent, aw_now, w_now;
    int cyc;
    aw_sent = 0; w_sent = 0; cyc = 0;
    @(posedge clk); #1;
    model_write(addr, data, strb);
    s_axil.awaddr  = addr;
    s_axil.awvalid = 1'b1;
    s_axil.wdata   = data;
    s_axil.wstrb   = strb;
    s_axil.wvalid  = (aw_lead == 0);
    while (!(aw_sent && w_sent) && cyc < 50) begin
      @(negedge clk);
      aw_now = s_axil.awvalid && s_axil.awready;
      w_now  = s_axil.wvalid && s_axil.wready;
      @(posedge clk); #1;
      if (aw_now) begin aw_sent = 1; s_axil.awvalid = 1'b0; end
      if (w_now)  begin w_sent = 1;  s_axil.wvalid  = 1'b0; end
      cyc++;
      if (cyc == aw_lead && !w_sent) s_axil.wvalid = 1'b1;
    end
    if (!(aw_sent && w_sent)) check_eq("write_hs_timeout", 0, 1);
    check_eq("bvalid_latency", {31'd0, s_axil.bvalid}, 1);
    if (s_axil.bready) begin
      cyc = 0;
      while (s_axil.bvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int hold);
    rexp_t e;
    bit hs, done;
    int cyc;
    done = 0; cyc = 0;
    @(posedge clk); #1;
    e = model_read(addr);
    exp_r.push_back(e);
    s_axil.araddr  = addr;
    s_axil.arvalid = 1'b1;
    s_axil.rready  = (hold == 0);
    while (!done && cyc < 50) begin
      @(negedge clk);
      hs = s_axil.arready;
      @(posedge clk); #1;
      if (hs) begin done = 1; s_axil.arvalid = 1'b0; end
      cyc++;
    end
    if (!done) check_eq("read_hs_timeout", 0, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("rhold_rvalid", {31'd0, s_axil.rvalid}, 1);
      check_eq("rhold_rdata", s_axil.rdata, e.data);
      check_eq("rhold_arready", {31'd0, s_axil.arready}, 0);
    end
    if (hold > 0) begin @(posedge clk); #1; s_axil.rready = 1'b1; end
    cyc = 0;
    while (s_axil.rvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (s_axil.rvalid) check_eq("rvalid_stuck", 1, 0);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      usr_raddr = i[3:0];
      #1;
      check_eq(tag, usr_rdata, model[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rexp_t e;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    rst_n = 1'b0;
    usr_raddr = 4'd0;
    s_axil.awaddr = '0; s_axil.awvalid = 1'b0;
    s_axil.wdata  = '0; s_axil.wstrb   = '0; s_axil.wvalid = 1'b0;
    s_axil.bready = 1'b1;
    s_axil.araddr = '0; s_axil.arvalid = 1'b0;
    s_axil.rready = 1'b1;
    #1;
    check_eq("rst_awready", {31'd0, s_axil.awready}, 1);
    check_eq("rst_wready",  {31'd0, s_axil.wready},  1);
    check_eq("rst_arready", {31'd0, s_axil.arready}, 1);
    check_eq("rst_bvalid",  {31'd0, s_axil.bvalid},  0);
    check_eq("rst_rvalid",  {31'd0, s_axil.rvalid},  0);
    check_eq("rst_bresp",   {30'd0, s_axil.bresp},   0);
    check_eq("rst_rresp",   {30'd0, s_axil.rresp},   0);
    check_eq("rst_rdata",   s_axil.rdata, 0);
    check_eq("rst_wr_pulse", {31'd0, wr_pulse}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Aligned full write, then observe it through the user port.
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0);
    usr_raddr = 4'd2; #1;
    check_eq("usr_idx2_full", usr_rdata, 32'hDEADBEEF);

    // AW leads W, then a partial strobe write over index 2.
    do_write(8'h10, 32'hA5A5A5A5, 4'hF, 3);
    do_write(8'h0A, 32'h11223344, 4'b0101, 0);
    usr_raddr = 4'd2; #1;
    check_eq("usr_idx2_partial", usr_rdata, 32'hDE22BE44);

    // Zero strobe: nothing changes, pulse still expected.
    do_write(8'h08, 32'hFFFFFFFF, 4'h0, 1);
    do_read(8'h08, 4);
    do_read(8'h10, 0);

    // Out-of-range write and read.
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 0);
    do_read(8'h40, 0);
    do_read(8'hFC, 2);
    check_all_regs("regs_after_oor");

    // Read and write colliding on index 3 in the same edge.
    do_write(8'h0C, 32'h5, 4'hF, 0);
    @(posedge clk); #1;
    e = model_read(8'h0C);
    exp_r.push_back(e);
    model_write(8'h0C, 32'h9, 4'hF);
    s_axil.awaddr = 8'h0C; s_axil.awvalid = 1'b1;
    s_axil.wdata = 32'h9;  s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
    s_axil.araddr = 8'h0C; s_axil.arvalid = 1'b1;
    @(posedge clk); #1;
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
    check_eq("collide_bvalid", {31'd0, s_axil.bvalid}, 1);
    check_eq("collide_rvalid", {31'd0, s_axil.rvalid}, 1);
    check_eq("collide_rdata_old", s_axil.rdata, 32'h5);
    repeat (3) @(posedge clk); #1;
    do_read(8'h0C, 0);
    usr_raddr = 4'd3; #1;
    check_eq("usr_idx3_new", usr_rdata, 32'h9);

    // Reset in the middle of a pending write response.
    s_axil.bready = 1'b0;
    do_write(8'h14, 32'hCAFEF00D, 4'hF, 0);
    @(posedge clk); #3;
    check_eq("pend_bvalid", {31'd0, s_axil.bvalid}, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_bvalid", {31'd0, s_axil.bvalid}, 0);
    exp_b.delete(); exp_wi.delete(); exp_r.delete();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    s_axil.bready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_awready", {31'd0, s_axil.awready}, 1);
    check_eq("post_rst_wready",  {31'd0, s_axil.wready},  1);
    check_eq("post_rst_arready", {31'd0, s_axil.arready}, 1);
    check_all_regs("regs_after_reset");
    do_read(8'h14, 0);

    repeat (3) @(posedge clk); #1;
    check_eq("b_left",  exp_b.size(),  0);
    check_eq("wi_left", exp_wi.size(), 0);
    check_eq("r_left",  exp_r.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
